// File: rtl/store_merge_unit.sv
// store_merge_unit
// Store-side narrowing for the MEM stage. Word stores are written directly;
// byte and half stores read the containing word, merge the addressed lanes
// (little-endian) and write the merged word back. The pipeline is stalled
// while an access is outstanding, and an unanswered access is abandoned
// after TIMEOUT cycles with an error pulse.
module store_merge_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    // Last count value at which an ack can still arrive before the abort.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

    // Reserved size, or an access that straddles its natural alignment.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lo[0];
            SIZE_WORD: bad = (lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Replace the addressed lanes of the old memory word with register data.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] reg_data,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        res = old_word;
        case (sz)
            SIZE_BYTE: res[{lane, 3'b000} +: 8]      = reg_data[7:0];
            SIZE_HALF: res[{lane[1], 4'b0000} +: 16] = reg_data[15:0];
            default:   res = reg_data;
        endcase
        return res;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  wait_cnt_r;
    logic [1:0]  lane_r;
    logic [1:0]  size_r;
    logic [31:0] data_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        done_r;
    logic        err_r;

    logic        accept_s;
    logic        misaligned_s;
    logic        busy_s;
    logic        timeout_s;
    logic        mem_rd_s;
    logic        mem_wr_s;
    logic        req_ready_s;
    logic        stall_s;

    assign accept_s     = req_valid && (state_r == ST_IDLE);
    assign misaligned_s = is_misaligned(size, addr[1:0]);
    assign busy_s       = (state_r == ST_READ) || (state_r == ST_WRITE);
    assign timeout_s    = busy_s && !mem_ack && (wait_cnt_r == TIMEOUT_LAST);

    // State register; async reset returns to IDLE so strobes drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode for the accept / read / write / abort flow.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !misaligned_s) begin
                    if (size == SIZE_WORD) begin
                        state_next_s = ST_WRITE;
                    end else begin
                        state_next_s = ST_READ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    state_next_s = ST_WRITE;
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (mem_ack || timeout_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Strobe and handshake decode straight from the state register.
    always_comb begin
        mem_rd_s    = 1'b0;
        mem_wr_s    = 1'b0;
        req_ready_s = 1'b0;
        stall_s     = 1'b1;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                stall_s     = 1'b0;
            end
            ST_READ:  mem_rd_s = 1'b1;
            ST_WRITE: mem_wr_s = 1'b1;
            default: begin
                mem_rd_s = 1'b0;
                mem_wr_s = 1'b0;
            end
        endcase
    end

    // Request capture, lane merge, wait counter and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r  <= 8'd0;
            lane_r      <= 2'b00;
            size_r      <= 2'b00;
            data_r      <= 32'd0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= (state_r == ST_WRITE) && mem_ack;
            err_r  <= (accept_s && misaligned_s) || timeout_s;
            // Counter restarts whenever the state changes, so it measures
            // only the wait inside the current READ or WRITE.
            if (state_next_s != state_r) begin
                wait_cnt_r <= 8'd0;
            end else if (busy_s) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
            if (accept_s && !misaligned_s) begin
                lane_r     <= addr[1:0];
                size_r     <= size;
                data_r     <= wdata;
                mem_addr_r <= {addr[31:2], 2'b00};
                if (size == SIZE_WORD) begin
                    mem_wdata_r <= wdata;
                end
            end else if ((state_r == ST_READ) && mem_ack) begin
                mem_wdata_r <= merge_lanes(mem_rdata, data_r, size_r, lane_r);
            end
        end
    end

    assign req_ready = req_ready_s;
    assign stall     = stall_s;
    assign mem_rd    = mem_rd_s;
    assign mem_wr    = mem_wr_s;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: a transaction-level model turns each accepted
// request into the expected per-cycle output trace, checked every cycle.
module tb_store_merge_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        ack_en;
    logic        ack_force;
    logic        chk_en;
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_val;

    logic [31:0] bmem [0:255];
    logic [31:0] mmem [0:255];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        dn;
        logic        er;
        logic        rdy;
        logic [31:0] a;
        logic [31:0] wd;
    } exp_t;

    exp_t q[$];

    store_merge_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .addr      (addr),
        .wdata     (wdata),
        .size      (size),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    // Memory responder: same-cycle ack when enabled, word-indexed storage.
    assign mem_rdata = bmem[mem_addr[9:2]];
    assign mem_ack   = ack_force | (ack_en & (mem_rd | mem_wr));

    always @(posedge clk) begin
        if (pl_en) bmem[pl_idx] <= pl_val;
        else if (mem_wr && mem_ack) bmem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(logic rd, logic wr, logic dn, logic er, logic rdy,
                                logic [31:0] a, logic [31:0] wd);
        exp_t e;
        e.rd = rd; e.wr = wr; e.dn = dn; e.er = er; e.rdy = rdy; e.a = a; e.wd = wd;
        return e;
    endfunction

    // Expand one accepted request into its expected output trace.
    task automatic model_accept(input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] s, input logic acks);
        int          nb;
        int          shift;
        logic [63:0] mask;
        logic [31:0] wa;
        logic [31:0] old;
        logic [31:0] nw;
        logic        misal;
        wa    = a & 32'hFFFF_FFFC;
        nb    = 1 << s;
        misal = (s == 2'd3) || ((a % nb) != 0);
        if (misal) begin
            q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0));
        end else if (!acks) begin
            for (int i = 0; i < TO; i++)
                q.push_back(mk(s != 2'd2, s == 2'd2, 1'b0, 1'b0, 1'b0, wa, d));
            q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0));
        end else begin
            shift = (a % 4) * 8;
            mask  = ((64'd1 << (8 * nb)) - 64'd1) << shift;
            old   = mmem[wa[9:2]];
            nw    = (old & ~mask[31:0]) | ((d << shift) & mask[31:0]);
            if (s != 2'd2) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, wa, 32'd0));
            q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, wa, nw));
            q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0));
            mmem[wa[9:2]] = nw;
        end
    endtask

    // Per-cycle compare against the model trace (idle when the trace is empty).
    always @(negedge clk) begin
        exp_t e;
        if (pl_en) mmem[pl_idx] = pl_val;
        if (!rst_n) begin
            q.delete();
        end else if (chk_en) begin
            if (q.size() > 0) e = q.pop_front();
            else e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
            chk("req_ready", {31'd0, req_ready}, {31'd0, e.rdy});
            chk("stall", {31'd0, stall}, {31'd0, !e.rdy});
            chk("mem_rd", {31'd0, mem_rd}, {31'd0, e.rd});
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, e.wr});
            chk("done", {31'd0, done}, {31'd0, e.dn});
            chk("err", {31'd0, err}, {31'd0, e.er});
            if (e.rd || e.wr) chk("mem_addr", mem_addr, e.a);
            if (e.wr) chk("mem_wdata", mem_wdata, e.wd);
            if (e.rdy && req_valid) model_accept(addr, wdata, size, ack_en);
        end
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        pl_idx = idx; pl_val = val; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until the handshake completes (bounded).
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        bit got;
        got = 1'b0;
        addr = a; wdata = d; size = s; req_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk); #1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL send_handshake addr=%h never accepted", a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req_valid = 1'b0; addr = 32'd0; wdata = 32'd0; size = 2'd0;
        ack_en = 1'b1; ack_force = 1'b0; chk_en = 1'b0;
        pl_en = 1'b0; pl_idx = 8'd0; pl_val = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Word store.
        preload(8'd64, 32'h0000_0000);
        send(32'h100, 32'hDEAD_BEEF, 2'b10);
        idle(3);
        chk("word_mem", bmem[64], 32'hDEAD_BEEF);

        // Byte store into lane 3.
        preload(8'd64, 32'h1122_3344);
        send(32'h103, 32'h1234_56AA, 2'b00);
        idle(4);
        chk("byte_mem", bmem[64], 32'hAA22_3344);
        chk("byte_model", mmem[64], 32'hAA22_3344);

        // Half stores, upper then lower half.
        preload(8'd64, 32'h1122_3344);
        send(32'h102, 32'hFFFF_5566, 2'b01);
        idle(4);
        chk("half_hi_mem", bmem[64], 32'h5566_3344);
        preload(8'd64, 32'h1122_3344);
        send(32'h100, 32'hFFFF_5566, 2'b01);
        idle(4);
        chk("half_lo_mem", bmem[64], 32'h1122_5566);

        // Misaligned and reserved sizes.
        preload(8'd64, 32'h1122_3344);
        send(32'h101, 32'h0000_7777, 2'b01);
        idle(2);
        send(32'h102, 32'h8888_8888, 2'b10);
        idle(2);
        send(32'h100, 32'h9999_9999, 2'b11);
        idle(2);
        chk("misal_mem", bmem[64], 32'h1122_3344);

        // Ack while idle is ignored.
        ack_force = 1'b1;
        idle(3);
        ack_force = 1'b0;
        idle(1);

        // Timeout on read with no ack.
        ack_en = 1'b0;
        send(32'h100, 32'h0000_0099, 2'b00);
        req_valid = 1'b0;
        n = 0;
        repeat (14) begin
            @(negedge clk);
            if (mem_rd) n++;
        end
        @(posedge clk); #1;
        ack_en = 1'b1;
        chk("timeout_rd_cycles", n, TO);
        chk("timeout_mem", bmem[64], 32'h1122_3344);

        // Reset in the middle of a write.
        preload(8'd128, 32'h0000_0000);
        ack_en = 1'b0;
        send(32'h200, 32'h1234_5678, 2'b10);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_wr_before", {31'd0, mem_wr}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wr_after", {31'd0, mem_wr}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_en = 1'b1;
        idle(2);
        chk("midrst_mem", bmem[128], 32'h0000_0000);

        // Back-to-back: second request accepted in the done cycle.
        preload(8'd128, 32'h0000_0000);
        send(32'h200, 32'h0102_0304, 2'b10);
        send(32'h201, 32'h0000_00EE, 2'b00);
        idle(6);
        chk("b2b_mem", bmem[128], 32'h0102_EE04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
